// File: rtl/vga_timing_pkg.sv
// Timing constants, capture FSM states and CRC constants shared by the VGA
// generator, the capture monitor and its benches.
package vga_timing_pkg;

    localparam int H_TOTAL_DEF        = 1525;
    localparam int H_SYNC_PULSE_DEF   = 183;
    localparam int H_ACTIVE_START_DEF = 274;
    localparam int H_DISPLAY_DEF      = 1220;
    localparam int V_TOTAL_DEF        = 525;
    localparam int V_ACTIVE_START_DEF = 34;
    localparam int V_DISPLAY_DEF      = 480;
    localparam int LOCK_FRAMES_DEF    = 2;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_e;

endpackage

// File: rtl/vga_capture_if.sv
// VGA pins plus recovered pixel/status signals of the capture monitor.
// err_count exists only when VGA_CAPTURE_ERRCNT_EN is defined.
interface vga_capture_if;

    logic        vga_hsync;
    logic        vga_vsync;
    logic [5:0]  vga_rgb;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [5:0]  pix_rgb;
    logic        locked;
    logic [10:0] line_len;
    logic [15:0] frame_crc;
    logic        crc_valid;
    logic        err_pulse;
`ifdef VGA_CAPTURE_ERRCNT_EN
    logic [7:0]  err_count;

    modport master (
        output vga_hsync, vga_vsync, vga_rgb,
        input  pix_valid, pix_x, pix_y, pix_rgb, locked, line_len,
               frame_crc, crc_valid, err_pulse, err_count
    );
    modport slave (
        input  vga_hsync, vga_vsync, vga_rgb,
        output pix_valid, pix_x, pix_y, pix_rgb, locked, line_len,
               frame_crc, crc_valid, err_pulse, err_count
    );
`else
    modport master (
        output vga_hsync, vga_vsync, vga_rgb,
        input  pix_valid, pix_x, pix_y, pix_rgb, locked, line_len,
               frame_crc, crc_valid, err_pulse
    );
    modport slave (
        input  vga_hsync, vga_vsync, vga_rgb,
        output pix_valid, pix_x, pix_y, pix_rgb, locked, line_len,
               frame_crc, crc_valid, err_pulse
    );
`endif

endinterface

// File: rtl/crc16_sym6.sv
// One CRC-16-CCITT update for a 6-bit symbol, MSB first, fully combinational.
module crc16_sym6
    import vga_timing_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [5:0]  sym,
    output logic [15:0] crc_out
);

    logic [15:0] w_crc;
    logic        w_fb;

    always_comb begin
        w_crc = crc_in;
        w_fb  = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            w_fb  = w_crc[15] ^ sym[i];
            w_crc = {w_crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);
        end
        crc_out = w_crc;
    end

endmodule

// File: rtl/vga_capture.sv
// VGA receive monitor: recovers pixel coordinates, checks line/frame timing,
// tracks lock and emits a per-frame CRC. VGA_CAPTURE_ERRCNT_EN adds err_count.
module vga_capture
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL        = H_TOTAL_DEF,
    parameter int H_SYNC_PULSE   = H_SYNC_PULSE_DEF,
    parameter int H_ACTIVE_START = H_ACTIVE_START_DEF,
    parameter int H_DISPLAY      = H_DISPLAY_DEF,
    parameter int V_TOTAL        = V_TOTAL_DEF,
    parameter int V_ACTIVE_START = V_ACTIVE_START_DEF,
    parameter int V_DISPLAY      = V_DISPLAY_DEF,
    parameter int LOCK_FRAMES    = LOCK_FRAMES_DEF
) (
    input  logic         clk48,
    input  logic         rst,
    vga_capture_if.slave bus
);

    logic        r_s_hsync, r_s_vsync, r_p_hsync, r_p_vsync;
    logic [5:0]  r_s_rgb;
    logic [10:0] r_x, r_hs_width;
    logic [9:0]  r_y;
    logic        r_vpend, r_seen_hfall, r_chk_width;
    logic [15:0] r_crc;
    state_e      r_state;
    logic [7:0]  r_clean;

    logic        r_pix_valid, r_locked, r_crc_valid, r_err_pulse;
    logic [10:0] r_pix_x, r_line_len;
    logic [9:0]  r_pix_y;
    logic [5:0]  r_pix_rgb;
    logic [15:0] r_frame_crc;

    logic        w_hfall, w_hrise, w_vfall, w_yreset, w_active, w_err;
    logic        w_len_err, w_width_err, w_frame_err;
    logic [10:0] w_x, w_frame_len;
    logic [9:0]  w_y;
    logic [11:0] w_line_len;
    logic [15:0] w_crc_next;

    assign w_hfall  = r_p_hsync & ~r_s_hsync;
    assign w_hrise  = ~r_p_hsync & r_s_hsync;
    assign w_vfall  = r_p_vsync & ~r_s_vsync;
    assign w_yreset = w_hfall & (r_vpend | w_vfall);

    // w_x/w_y are the coordinates of the sample currently held in the s_ stage
    assign w_x = w_hfall ? 11'd0 : ((r_x == 11'h7FF) ? r_x : r_x + 11'd1);
    assign w_y = !w_hfall ? r_y :
                 w_yreset ? 10'd0 :
                 ((r_y == 10'h3FF) ? r_y : r_y + 10'd1);

    assign w_line_len  = {1'b0, r_x} + 12'd1;
    assign w_frame_len = {1'b0, r_y} + 11'd1;

    // The first partial line and the first hsync pulse after reset are never judged
    assign w_len_err   = w_hfall & r_seen_hfall & (w_line_len != 12'(H_TOTAL));
    assign w_width_err = w_hrise & r_chk_width & (r_hs_width != 11'(H_SYNC_PULSE));
    assign w_frame_err = w_yreset & (r_state != SEARCH) & (w_frame_len != 11'(V_TOTAL));
    assign w_err       = w_len_err | w_width_err | w_frame_err;

    assign w_active = ({1'b0, w_x} >= 12'(H_ACTIVE_START)) &&
                      ({1'b0, w_x} <  12'(H_ACTIVE_START + H_DISPLAY)) &&
                      ({1'b0, w_y} >= 11'(V_ACTIVE_START)) &&
                      ({1'b0, w_y} <  11'(V_ACTIVE_START + V_DISPLAY));

    crc16_sym6 u_crc (
        .crc_in  (r_crc),
        .sym     (r_s_rgb),
        .crc_out (w_crc_next)
    );

    always_ff @(posedge clk48) begin
        if (rst) begin
            r_s_hsync    <= 1'b1;
            r_s_vsync    <= 1'b1;
            r_p_hsync    <= 1'b1;
            r_p_vsync    <= 1'b1;
            r_s_rgb      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_hs_width   <= '0;
            r_vpend      <= 1'b0;
            r_seen_hfall <= 1'b0;
            r_chk_width  <= 1'b0;
            r_crc        <= CRC_INIT;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_rgb    <= '0;
            r_line_len   <= '0;
            r_frame_crc  <= '0;
            r_crc_valid  <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_s_hsync <= bus.vga_hsync;
            r_s_vsync <= bus.vga_vsync;
            r_s_rgb   <= bus.vga_rgb;
            r_p_hsync <= r_s_hsync;
            r_p_vsync <= r_s_vsync;
            r_x       <= w_x;
            r_y       <= w_y;

            if (w_yreset)     r_vpend <= 1'b0;
            else if (w_vfall) r_vpend <= 1'b1;

            if (w_hfall) begin
                r_seen_hfall <= 1'b1;
                r_chk_width  <= r_seen_hfall;
                r_hs_width   <= 11'd1;
                r_line_len   <= w_line_len[11] ? 11'h7FF : w_line_len[10:0];
            end else if (!r_s_hsync && r_hs_width != 11'h7FF) begin
                r_hs_width <= r_hs_width + 11'd1;
            end

            if (w_yreset)      r_crc <= CRC_INIT;
            else if (w_active) r_crc <= w_crc_next;

            r_crc_valid <= w_yreset && (r_state != SEARCH);
            if (w_yreset && (r_state != SEARCH)) r_frame_crc <= r_crc;

            r_pix_valid <= w_active;
            r_pix_x     <= w_x - 11'(H_ACTIVE_START);
            r_pix_y     <= w_y - 10'(V_ACTIVE_START);
            r_pix_rgb   <= r_s_rgb;
            r_err_pulse <= w_err;
        end
    end

    // Lock FSM reacts to the registered err_pulse, so locked drops one cycle after it
    always_ff @(posedge clk48) begin
        if (rst) begin
            r_state  <= SEARCH;
            r_clean  <= '0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_yreset) begin
                        r_state <= MEASURE;
                        r_clean <= '0;
                    end
                end
                MEASURE: begin
                    if (r_err_pulse) begin
                        r_state <= SEARCH;
                        r_clean <= '0;
                    end else if (w_yreset && !w_err) begin
                        r_clean <= r_clean + 8'd1;
                        if (int'(r_clean) + 1 >= LOCK_FRAMES) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (r_err_pulse) begin
                        r_state  <= SEARCH;
                        r_clean  <= '0;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk48) begin
        if (rst)                              r_err_count <= '0;
        else if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end

    assign bus.err_count = r_err_count;
`endif

    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_x     = r_pix_x;
    assign bus.pix_y     = r_pix_y;
    assign bus.pix_rgb   = r_pix_rgb;
    assign bus.locked    = r_locked;
    assign bus.line_len  = r_line_len;
    assign bus.frame_crc = r_frame_crc;
    assign bus.crc_valid = r_crc_valid;
    assign bus.err_pulse = r_err_pulse;

endmodule
